// File: rtl/leaf_replay_relay.sv
// Registered relay: records valid leaf packets in a 2^DEPTH_BITS history, replays them into idle cycles after resend; 1-cycle live latency, no backpressure.
// Optional LEAF_REPLAY_STATS_EN adds replayed_pkts / aborted_replays counters.
module leaf_replay_relay #(
  parameter int PACKET_BITS = 49,
  parameter int DEPTH_BITS  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PACKET_BITS-1:0] din_pkt,
  input  logic                   resend,
  output logic [PACKET_BITS-1:0] dout_pkt,
  output logic                   replay_busy,
`ifdef LEAF_REPLAY_STATS_EN
  output logic [15:0]            replayed_pkts,
  output logic [7:0]             aborted_replays,
`endif
  output logic                   overrun
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] DEPTH_CNT = (DEPTH_BITS+1)'(DEPTH);
  localparam logic [DEPTH_BITS:0] ONE_CNT   = (DEPTH_BITS+1)'(1);

  typedef enum logic [1:0] {IDLE, HOLD, REPLAY} state_t;

  state_t                 state_q, state_d;
  logic [DEPTH_BITS-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]    count_q, count_d;
  logic [DEPTH_BITS:0]    remaining_q, remaining_d;
  logic [PACKET_BITS-1:0] dout_q, dout_d;
  logic                   overrun_q, overrun_d;
  logic                   wr_en;
  logic                   din_vld;
  logic [PACKET_BITS-1:0] mem_q [DEPTH];
  logic [PACKET_BITS-1:0] ram_q;

  assign din_vld = din_pkt[PACKET_BITS-1];

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    dout_d      = '0;
    overrun_d   = overrun_q;
    wr_en       = 1'b0;
    case (state_q)
      IDLE: begin
        dout_d = din_pkt;
        wr_en  = din_vld;
        if (resend) state_d = HOLD;
      end
      HOLD: begin
        if (!resend) begin
          rd_ptr_d    = wr_ptr_q - count_q[DEPTH_BITS-1:0];
          remaining_d = count_q;
          state_d     = (count_q != '0) ? REPLAY : IDLE;
        end
      end
      REPLAY: begin
        if (resend) begin
          state_d = HOLD;
        end else if (din_vld) begin
          dout_d = din_pkt;
          wr_en  = 1'b1;
          // Live write landing on the next unreplayed slot destroys the replay.
          if (wr_ptr_q == rd_ptr_q && remaining_q != '0) begin
            overrun_d = 1'b1;
            state_d   = IDLE;
          end
        end else begin
          dout_d      = ram_q;
          rd_ptr_d    = rd_ptr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == ONE_CNT) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (count_q != DEPTH_CNT) count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      dout_q      <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      dout_q      <= dout_d;
      overrun_q   <= overrun_d;
    end
  end

  // Read address is the next rd_ptr, so ram_q always holds history[rd_ptr_q].
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din_pkt;
    ram_q <= mem_q[rd_ptr_d];
  end

  assign dout_pkt    = dout_q;
  assign replay_busy = (state_q == REPLAY);
  assign overrun     = overrun_q;

`ifdef LEAF_REPLAY_STATS_EN
  logic        replay_rd;
  logic        replay_abort;
  logic [15:0] replayed_q;
  logic [7:0]  aborted_q;

  assign replay_rd    = (state_q == REPLAY) && !resend && !din_vld;
  assign replay_abort = (state_q == REPLAY) &&
                        (resend || (din_vld && wr_ptr_q == rd_ptr_q && remaining_q != '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      replayed_q <= '0;
      aborted_q  <= '0;
    end else begin
      if (replay_rd) replayed_q <= replayed_q + 16'd1;
      if (replay_abort && aborted_q != 8'hFF) aborted_q <= aborted_q + 8'd1;
    end
  end

  assign replayed_pkts   = replayed_q;
  assign aborted_replays = aborted_q;
`endif

endmodule

// File: tb/tb_leaf_replay_relay.sv
// Scoreboard bench for leaf_replay_relay: every driven cycle queues the dout expected after its edge.
module tb_leaf_replay_relay;

  localparam int PB = 49;

  logic          clk = 1'b0;
  logic          reset;
  logic [PB-1:0] din_pkt;
  logic          resend;
  logic [PB-1:0] dout_pkt;
  logic          replay_busy;
  logic          overrun;
`ifdef LEAF_REPLAY_STATS_EN
  logic [15:0]   replayed_pkts;
  logic [7:0]    aborted_replays;
`endif

  leaf_replay_relay #(.PACKET_BITS(PB), .DEPTH_BITS(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .din_pkt         (din_pkt),
    .resend          (resend),
    .dout_pkt        (dout_pkt),
    .replay_busy     (replay_busy),
`ifdef LEAF_REPLAY_STATS_EN
    .replayed_pkts   (replayed_pkts),
    .aborted_replays (aborted_replays),
`endif
    .overrun         (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            due;
    logic [PB-1:0] val;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;
  int busy_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [PB-1:0] P(input int v);
    return {1'b1, 48'(v)};
  endfunction

  // Drive one cycle of stimulus; queue the dout expected right after this edge.
  task automatic drive(input logic [PB-1:0] d, input logic rs, input logic [PB-1:0] e);
    din_pkt = d;
    resend  = rs;
    sb.push_back('{due: cyc + 1, val: e});
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      check("dout_pkt", 64'(dout_pkt), 64'(sb[0].val));
      void'(sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    din_pkt = '0;
    resend  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", 64'(dout_pkt), 64'd0);
    check("rst_busy", 64'(replay_busy), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    reset = 1'b0;

    // Three live packets, 1-cycle latency
    drive(P('hA), 1'b0, P('hA));
    drive(P('hB), 1'b0, P('hB));
    drive(P('hC), 1'b0, P('hC));
    check("live_busy", 64'(replay_busy), 64'd0);
    drive('0, 1'b0, '0);

    // Resend 4 cycles, then replay A,B,C
    for (int i = 0; i < 4; i++) drive('0, 1'b1, '0);
    check("hold_busy", 64'(replay_busy), 64'd0);
    busy_cnt = 0;
    drive('0, 1'b0, '0);
    busy_cnt += int'(replay_busy);
    drive('0, 1'b0, P('hA));
    busy_cnt += int'(replay_busy);
    drive('0, 1'b0, P('hB));
    busy_cnt += int'(replay_busy);
    drive('0, 1'b0, P('hC));
    busy_cnt += int'(replay_busy);
    drive('0, 1'b0, '0);
    busy_cnt += int'(replay_busy);
    check("busy_cycles", 64'(busy_cnt), 64'd3);

    // 20 packets wrap the 16-deep history; replay yields 5..20
    for (int k = 1; k <= 20; k++) drive(P(k), 1'b0, P(k));
    drive('0, 1'b1, '0);
    drive('0, 1'b1, '0);
    drive('0, 1'b0, '0);
    for (int k = 5; k <= 20; k++) drive('0, 1'b0, P(k));
    check("wrap_busy_end", 64'(replay_busy), 64'd0);
    drive('0, 1'b0, '0);
    check("wrap_overrun", 64'(overrun), 64'd0);

    // Live 0x55 on 2nd replay cycle takes the slot, replay resumes
    drive('0, 1'b1, '0);
    drive('0, 1'b1, '0);
    drive('0, 1'b0, '0);
    drive('0, 1'b0, P(5));
    drive(P('h55), 1'b0, P('h55));
    check("inject_busy", 64'(replay_busy), 64'd1);
    for (int k = 6; k <= 20; k++) drive('0, 1'b0, P(k));
    drive('0, 1'b0, '0);
    check("inject_overrun", 64'(overrun), 64'd0);

    // Full history, live traffic on first replay cycle clobbers it
    drive('0, 1'b1, '0);
    drive('0, 1'b1, '0);
    drive('0, 1'b0, '0);
    check("ovr_busy_pre", 64'(replay_busy), 64'd1);
    drive(P('h100), 1'b0, P('h100));
    check("ovr_flag", 64'(overrun), 64'd1);
    check("ovr_busy", 64'(replay_busy), 64'd0);
    drive(P('h101), 1'b0, P('h101));
    drive(P('h102), 1'b0, P('h102));
    drive('0, 1'b0, '0);

    // Resend mid-replay restarts from oldest (9); reset mid second replay
    drive('0, 1'b1, '0);
    drive('0, 1'b1, '0);
    drive('0, 1'b0, '0);
    drive('0, 1'b0, P(9));
    drive('0, 1'b0, P(10));
    drive('0, 1'b1, '0);
    check("abort_busy", 64'(replay_busy), 64'd0);
    drive('0, 1'b1, '0);
    drive('0, 1'b0, '0);
    drive('0, 1'b0, P(9));
    drive('0, 1'b0, P(10));
    drive('0, 1'b0, P(11));
    check("sticky_overrun", 64'(overrun), 64'd1);
    reset = 1'b1;
    drive('0, 1'b0, '0);
    reset = 1'b0;
    check("rst2_busy", 64'(replay_busy), 64'd0);
    check("rst2_overrun", 64'(overrun), 64'd0);
    drive('0, 1'b1, '0);
    drive('0, 1'b1, '0);
    drive('0, 1'b0, '0);
    check("empty_busy", 64'(replay_busy), 64'd0);
    drive('0, 1'b0, '0);
    drive('0, 1'b0, '0);
    check("empty_busy2", 64'(replay_busy), 64'd0);

    @(negedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
